// File: rtl/muldiv_defs.sv
// Shared opcode constants, FSM state type and operand-class helpers
// for the iterative M-extension multiply/divide unit.
package muldiv_defs;

  // Opcode values follow the RV32M funct3 encoding.
  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } md_state_e;

  function automatic logic md_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic md_is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  // DIV and REM: the only ops that can hit signed overflow.
  function automatic logic md_signed_div(input logic [2:0] op);
    return op[2] & ~op[0];
  endfunction

  function automatic logic md_rs1_signed(input logic [2:0] op);
    return op[2] ? ~op[0] : (op != MD_MULHU);
  endfunction

  function automatic logic md_rs2_signed(input logic [2:0] op);
    return op[2] ? ~op[0] : ((op == MD_MUL) || (op == MD_MULH));
  endfunction

endpackage

// File: rtl/muldiv_divstep.sv
// Combinational restoring-division step retiring DIV_BITS quotient bits,
// most significant first.
module muldiv_divstep #(
  parameter int XLEN     = 32,
  parameter int DIV_BITS = 1
) (
  input  logic [XLEN-1:0]     rem_i,
  input  logic [DIV_BITS-1:0] bits_i,
  input  logic [XLEN-1:0]     divisor_i,
  output logic [XLEN-1:0]     rem_o,
  output logic [DIV_BITS-1:0] quo_o
);

  logic [XLEN-1:0] rem_chain [DIV_BITS+1];

  assign rem_chain[0] = rem_i;

  generate
    for (genvar gi = 0; gi < DIV_BITS; gi++) begin : g_stage
      logic [XLEN:0] shifted;
      logic [XLEN:0] diff;
      logic          ge;
      assign shifted = {rem_chain[gi], bits_i[DIV_BITS-1-gi]};
      assign ge      = shifted >= {1'b0, divisor_i};
      assign diff    = shifted - {1'b0, divisor_i};
      // Remainder stays below the divisor, so either branch fits in XLEN bits.
      assign rem_chain[gi+1]       = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
      assign quo_o[DIV_BITS-1-gi]  = ge;
    end
  endgenerate

  assign rem_o = rem_chain[DIV_BITS];

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit beside EX: stalls the pipeline while
// computing and returns a one-cycle write-back pulse; flushable at any time.
module ex_muldiv
  import muldiv_defs::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 2,
  parameter int DIV_BITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] reg1_i,
  input  logic [XLEN-1:0] reg2_i,
  input  logic [4:0]      wd_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            stall_req_o,
  output logic            valid_o,
  output logic [4:0]      wd_o,
  output logic [XLEN-1:0] wdata_o
);

  localparam int MUL_N = XLEN / MUL_BITS;
  localparam int DIV_N = XLEN / DIV_BITS;
  localparam int CW    = $clog2(XLEN) + 1;

  md_state_e         state_reg, state_next;
  logic [2:0]        op_reg, op_next;
  logic [4:0]        wd_reg, wd_next;
  logic              neg1_reg, neg1_next;
  logic              neg2_reg, neg2_next;
  logic [XLEN-1:0]   a_reg, a_next;
  logic [XLEN-1:0]   b_reg, b_next;
  logic [2*XLEN-1:0] prod_reg, prod_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [4:0]        wd_out_reg, wd_out_next;
  logic [XLEN-1:0]   wdata_reg, wdata_next;

  logic              accept;
  logic              in_neg1, in_neg2;
  logic [XLEN-1:0]   in_abs1, in_abs2;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   special_res;

  assign accept  = start_i & (state_reg == ST_IDLE) & ~flush_i;
  assign in_neg1 = md_rs1_signed(op_i) & reg1_i[XLEN-1];
  assign in_neg2 = md_rs2_signed(op_i) & reg2_i[XLEN-1];
  assign in_abs1 = in_neg1 ? -reg1_i : reg1_i;
  assign in_abs2 = in_neg2 ? -reg2_i : reg2_i;

  assign div_zero = md_is_div(op_i) & (reg2_i == '0);
  assign div_ovf  = md_signed_div(op_i) & (reg1_i == {1'b1, {(XLEN-1){1'b0}}}) & (&reg2_i);
  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = md_is_rem(op_i) ? reg1_i : '1;
    else if (div_ovf)
      special_res = md_is_rem(op_i) ? '0 : reg1_i;
  end

  // Multiply step: add multiplicand x low digit into the high half, shift right.
  logic [MUL_BITS-1:0]      mul_digit;
  logic [XLEN+MUL_BITS-1:0] pp_terms [MUL_BITS];
  logic [XLEN+MUL_BITS-1:0] pp_sum;
  logic [XLEN+MUL_BITS-1:0] hi_sum;
  logic [2*XLEN-1:0]        mul_prod_next;

  assign mul_digit = prod_reg[MUL_BITS-1:0];

  generate
    for (genvar gi = 0; gi < MUL_BITS; gi++) begin : g_pp
      assign pp_terms[gi] = mul_digit[gi] ? ({{MUL_BITS{1'b0}}, a_reg} << gi) : '0;
    end
  endgenerate

  always_comb begin
    pp_sum = '0;
    for (int i = 0; i < MUL_BITS; i++)
      pp_sum = pp_sum + pp_terms[i];
  end

  assign hi_sum        = {{MUL_BITS{1'b0}}, prod_reg[2*XLEN-1:XLEN]} + pp_sum;
  assign mul_prod_next = {hi_sum, prod_reg[XLEN-1:MUL_BITS]};

  // Divide step: high half is the partial remainder, low half shifts dividend out / quotient in.
  logic [XLEN-1:0]     div_rem;
  logic [DIV_BITS-1:0] div_quo;
  logic [2*XLEN-1:0]   div_prod_next;

  muldiv_divstep #(
    .XLEN     (XLEN),
    .DIV_BITS (DIV_BITS)
  ) u_divstep (
    .rem_i     (prod_reg[2*XLEN-1:XLEN]),
    .bits_i    (prod_reg[XLEN-1:XLEN-DIV_BITS]),
    .divisor_i (b_reg),
    .rem_o     (div_rem),
    .quo_o     (div_quo)
  );

  generate
    if (DIV_BITS < XLEN) begin : g_div_shift
      assign div_prod_next = {div_rem, prod_reg[XLEN-DIV_BITS-1:0], div_quo};
    end else begin : g_div_whole
      assign div_prod_next = {div_rem, div_quo};
    end
  endgenerate

  // Sign correction and result selection.
  logic [2*XLEN-1:0] prod_signed;
  logic [XLEN-1:0]   quo_signed, rem_signed, fix_res;
  logic              calc_last;

  assign prod_signed = (neg1_reg ^ neg2_reg) ? -prod_reg : prod_reg;
  assign quo_signed  = (neg1_reg ^ neg2_reg) ? -prod_reg[XLEN-1:0] : prod_reg[XLEN-1:0];
  assign rem_signed  = neg1_reg ? -prod_reg[2*XLEN-1:XLEN] : prod_reg[2*XLEN-1:XLEN];

  always_comb begin
    fix_res = prod_signed[2*XLEN-1:XLEN];
    if (op_reg == MD_MUL)
      fix_res = prod_signed[XLEN-1:0];
    else if (md_is_div(op_reg))
      fix_res = md_is_rem(op_reg) ? rem_signed : quo_signed;
  end

  assign calc_last = md_is_div(op_reg) ? (cnt_reg == CW'(DIV_N - 1))
                                       : (cnt_reg == CW'(MUL_N - 1));

  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    wd_next     = wd_reg;
    neg1_next   = neg1_reg;
    neg2_next   = neg2_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    prod_next   = prod_reg;
    cnt_next    = cnt_reg;
    wd_out_next = wd_out_reg;
    wdata_next  = wdata_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          op_next   = op_i;
          wd_next   = wd_i;
          neg1_next = in_neg1;
          neg2_next = in_neg2;
          a_next    = in_abs1;
          b_next    = in_abs2;
          cnt_next  = '0;
          if (div_zero || div_ovf) begin
            prod_next   = '0;
            wdata_next  = special_res;
            wd_out_next = wd_i;
            state_next  = ST_DONE;
          end else begin
            prod_next  = {{XLEN{1'b0}}, md_is_div(op_i) ? in_abs1 : in_abs2};
            state_next = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        prod_next = md_is_div(op_reg) ? div_prod_next : mul_prod_next;
        if (calc_last) begin
          cnt_next   = '0;
          state_next = ST_FIX;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_FIX: begin
        wdata_next  = fix_res;
        wd_out_next = wd_reg;
        state_next  = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (flush_i)
      state_next = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      op_reg     <= '0;
      wd_reg     <= '0;
      neg1_reg   <= 1'b0;
      neg2_reg   <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      prod_reg   <= '0;
      cnt_reg    <= '0;
      wd_out_reg <= '0;
      wdata_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      wd_reg     <= wd_next;
      neg1_reg   <= neg1_next;
      neg2_reg   <= neg2_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      prod_reg   <= prod_next;
      cnt_reg    <= cnt_next;
      wd_out_reg <= wd_out_next;
      wdata_reg  <= wdata_next;
    end
  end

  assign ready_o     = (state_reg == ST_IDLE);
  assign stall_req_o = accept | (state_reg == ST_CALC) | (state_reg == ST_FIX);
  assign valid_o     = (state_reg == ST_DONE) & ~flush_i;
  assign wd_o        = wd_out_reg;
  assign wdata_o     = wdata_reg;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed-vector bench for ex_muldiv: a 32-bit default instance plus a
// 16-bit instance with MUL_BITS=4 / DIV_BITS=2.
module tb_ex_muldiv;
  import muldiv_defs::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start_a = 1'b0, flush_a = 1'b0;
  logic [2:0]  op_a = '0;
  logic [31:0] r1_a = '0, r2_a = '0;
  logic [4:0]  wd_a = '0;
  logic        rdy_a, stall_a, valid_a;
  logic [4:0]  wdo_a;
  logic [31:0] wdata_a;

  logic        start_b = 1'b0, flush_b = 1'b0;
  logic [2:0]  op_b = '0;
  logic [15:0] r1_b = '0, r2_b = '0;
  logic [4:0]  wd_b = '0;
  logic        rdy_b, stall_b, valid_b;
  logic [4:0]  wdo_b;
  logic [15:0] wdata_b;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  ex_muldiv #(.XLEN(32), .MUL_BITS(2), .DIV_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .start_i(start_a), .op_i(op_a), .reg1_i(r1_a), .reg2_i(r2_a),
    .wd_i(wd_a), .flush_i(flush_a), .ready_o(rdy_a), .stall_req_o(stall_a),
    .valid_o(valid_a), .wd_o(wdo_a), .wdata_o(wdata_a)
  );

  ex_muldiv #(.XLEN(16), .MUL_BITS(4), .DIV_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .start_i(start_b), .op_i(op_b), .reg1_i(r1_b), .reg2_i(r2_b),
    .wd_i(wd_b), .flush_i(flush_b), .ready_o(rdy_b), .stall_req_o(stall_b),
    .valid_o(valid_b), .wd_o(wdo_b), .wdata_o(wdata_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // sel=0 drives the 32-bit instance, sel=1 the 16-bit one.
  task automatic run_op(input bit sel, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wd,
                        input logic [31:0] exp, input int lat, input string tag);
    int          stalls;
    int          vcyc;
    logic [31:0] got;
    logic [4:0]  got_wd;
    stalls = 0;
    vcyc   = -1;
    got    = '0;
    got_wd = '0;
    @(negedge clk);
    if (!sel) begin
      start_a = 1'b1; op_a = op; r1_a = a; r2_a = b; wd_a = wd;
    end else begin
      start_b = 1'b1; op_b = op; r1_b = a[15:0]; r2_b = b[15:0]; wd_b = wd;
    end
    #1;
    check({tag, "/ready"}, 64'(sel ? rdy_b : rdy_a), 64'd1);
    stalls += int'(sel ? stall_b : stall_a);
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    for (int c = 1; c <= 100 && vcyc < 0; c++) begin
      @(negedge clk);
      stalls += int'(sel ? stall_b : stall_a);
      if (sel ? valid_b : valid_a) begin
        vcyc   = c;
        got    = sel ? {16'h0, wdata_b} : wdata_a;
        got_wd = sel ? wdo_b : wdo_a;
      end
    end
    check({tag, "/latency"}, 64'(vcyc), 64'(lat));
    check({tag, "/wdata"}, 64'(got), 64'(exp));
    check({tag, "/wd"}, 64'(got_wd), 64'(wd));
    check({tag, "/stall_cycles"}, 64'(stalls), 64'(lat));
    @(negedge clk);
    check({tag, "/valid_drop"}, 64'(sel ? valid_b : valid_a), 64'd0);
    check({tag, "/wdata_hold"}, 64'(sel ? {16'h0, wdata_b} : wdata_a), 64'(exp));
    $display("op %s %0h,%0h -> %0h (cycle %0d)", tag, a, b, got, vcyc);
  endtask

  initial begin : main
    int vcount;
    #1;
    check("reset/valid", 64'(valid_a), 64'd0);
    check("reset/wd", 64'(wdo_a), 64'd0);
    check("reset/wdata", 64'(wdata_a), 64'd0);
    check("reset/stall", 64'(stall_a), 64'd0);
    check("reset/ready", 64'(rdy_a), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(0, MD_MUL,    32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 18, "MUL 7*-3");
    run_op(0, MD_MULH,   32'd7,        32'hFFFFFFFD, 5'd2,  32'hFFFFFFFF, 18, "MULH 7*-3");
    run_op(0, MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE, 18, "MULHU");
    run_op(0, MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFF, 18, "MULHSU");
    run_op(0, MD_MULH,   32'h80000000, 32'h80000000, 5'd5,  32'h40000000, 18, "MULH min*min");
    run_op(0, MD_MUL,    32'h80000000, 32'd2,        5'd6,  32'h00000000, 18, "MUL min*2");
    run_op(0, MD_DIV,    32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD, 34, "DIV -7/2");
    run_op(0, MD_REM,    32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF, 34, "REM -7/2");
    run_op(0, MD_DIVU,   32'd100,      32'd7,        5'd9,  32'd14,       34, "DIVU 100/7");
    run_op(0, MD_REMU,   32'd100,      32'd7,        5'd10, 32'd2,        34, "REMU 100/7");
    run_op(0, MD_DIV,    32'd100,      32'hFFFFFFF9, 5'd11, 32'hFFFFFFF2, 34, "DIV 100/-7");
    run_op(0, MD_REM,    32'd100,      32'hFFFFFFF9, 5'd12, 32'd2,        34, "REM 100/-7");
    run_op(0, MD_REM,    32'hFFFFFF9C, 32'd7,        5'd13, 32'hFFFFFFFE, 34, "REM -100/7");
    run_op(0, MD_DIVU,   32'hFFFFFFFF, 32'd1,        5'd14, 32'hFFFFFFFF, 34, "DIVU max/1");
    run_op(0, MD_DIV,    32'd5,        32'd0,        5'd15, 32'hFFFFFFFF, 1,  "DIV 5/0");
    run_op(0, MD_REMU,   32'd5,        32'd0,        5'd16, 32'd5,        1,  "REMU 5/0");
    run_op(0, MD_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000, 1,  "DIV ovf");
    run_op(0, MD_REM,    32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h00000000, 1,  "REM ovf");

    // Flush at cycle 10 of a divide.
    @(negedge clk);
    start_a = 1'b1; op_a = MD_DIV; r1_a = 32'd100; r2_a = 32'd7; wd_a = 5'd19;
    @(posedge clk);
    #1 start_a = 1'b0;
    repeat (10) @(negedge clk);
    flush_a = 1'b1;
    @(posedge clk);
    #1 flush_a = 1'b0;
    @(negedge clk);
    check("flush/ready_c11", 64'(rdy_a), 64'd1);
    check("flush/stall_c11", 64'(stall_a), 64'd0);
    vcount = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      vcount += int'(valid_a);
    end
    check("flush/no_valid", 64'(vcount), 64'd0);
    $display("op flush DIV at cycle 10 -> %0d valid pulses", vcount);

    // Flush while in DONE hides the pulse.
    @(negedge clk);
    start_a = 1'b1; op_a = MD_DIV; r1_a = 32'd5; r2_a = 32'd0; wd_a = 5'd20;
    @(posedge clk);
    #1 start_a = 1'b0;
    @(negedge clk);
    flush_a = 1'b1;
    #1;
    check("flush_done/valid", 64'(valid_a), 64'd0);
    @(posedge clk);
    #1 flush_a = 1'b0;
    @(negedge clk);
    check("flush_done/ready", 64'(rdy_a), 64'd1);
    $display("op flush in DONE -> valid %0d", valid_a);

    // Reset mid-CALC clears outputs at once; unit recovers.
    @(negedge clk);
    start_a = 1'b1; op_a = MD_MUL; r1_a = 32'd3; r2_a = 32'd5; wd_a = 5'd21;
    @(posedge clk);
    #1 start_a = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid/valid", 64'(valid_a), 64'd0);
    check("rst_mid/wd", 64'(wdo_a), 64'd0);
    check("rst_mid/wdata", 64'(wdata_a), 64'd0);
    check("rst_mid/stall", 64'(stall_a), 64'd0);
    check("rst_mid/ready", 64'(rdy_a), 64'd1);
    $display("op reset mid-CALC -> wdata %0h", wdata_a);
    @(negedge clk);
    rst = 1'b0;
    run_op(0, MD_MUL, 32'd3, 32'd5, 5'd22, 32'd15, 18, "MUL 3*5 post-rst");

    // 16-bit instance: MUL N=4 -> cycle 6, DIV N=8 -> cycle 10.
    run_op(1, MD_MUL,    32'h1234, 32'h0010, 5'd1, 32'h2340, 6,  "B MUL");
    run_op(1, MD_MULHU,  32'hFFFF, 32'hFFFF, 5'd2, 32'hFFFE, 6,  "B MULHU");
    run_op(1, MD_MULH,   32'h8000, 32'h8000, 5'd3, 32'h4000, 6,  "B MULH");
    run_op(1, MD_MULHSU, 32'hFFFF, 32'hFFFF, 5'd4, 32'hFFFF, 6,  "B MULHSU");
    run_op(1, MD_DIV,    32'hFFF9, 32'd2,    5'd5, 32'hFFFD, 10, "B DIV -7/2");
    run_op(1, MD_REM,    32'hFFF9, 32'd2,    5'd6, 32'hFFFF, 10, "B REM -7/2");
    run_op(1, MD_DIVU,   32'd1000, 32'd7,    5'd7, 32'd142,  10, "B DIVU");
    run_op(1, MD_REMU,   32'd1000, 32'd7,    5'd8, 32'd6,    10, "B REMU");
    run_op(1, MD_DIV,    32'h8000, 32'hFFFF, 5'd9, 32'h8000, 1,  "B DIV ovf");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vec_cnt);
    $fatal(1, "watchdog expired");
  end

endmodule
